// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder
//   One TMDS channel decoder for the video-input path. Takes 10-bit words
//   from an external 1:10 deserializer, bit-slips until control tokens
//   repeat at a fixed boundary, then decodes TMDS symbols.
//
//   Ports:
//     clk_i          pixel clock (only clock)
//     rst_ni         synchronous active-low reset
//     raw_i[9:0]     deserialized word, bit 0 first on the wire
//     data_o[7:0]    decoded pixel byte (0 unless locked data symbol)
//     de_o           data enable
//     ctrl_o[1:0]    {C1,C0} of the last control token
//     locked_o       symbol alignment achieved
//     offset_o[3:0]  current bit-slip offset, 0..9
//     loss_cnt_o     lock-loss event counter
//     loss_cnt_clr_i clears loss_cnt_o
//
//   Optional feature macro: TMDS_DEC_LOSS_CNT_EN
//     defined   : loss_cnt_o counts LOCKED->SEARCH transitions, saturating,
//                 clear has priority over increment
//     undefined : loss_cnt_o is 0 and loss_cnt_clr_i is ignored
//
//   Pipeline: raw_q (stage 1), sym (stage 2), outputs + FSM (stage 3).
module tmds_channel_decoder #(
  parameter int CTRL_RUN     = 8,
  parameter int SEARCH_WIN   = 4096,
  parameter int LOSS_TIMEOUT = 4096
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [9:0]  raw_i,
  output logic [7:0]  data_o,
  output logic        de_o,
  output logic [1:0]  ctrl_o,
  output logic        locked_o,
  output logic [3:0]  offset_o,
  output logic [15:0] loss_cnt_o,
  input  logic        loss_cnt_clr_i
);

  localparam int RUN_W  = $clog2(CTRL_RUN);
  localparam int WIN_W  = $clog2(SEARCH_WIN);
  localparam int IDLE_W = $clog2(LOSS_TIMEOUT);

  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(CTRL_RUN - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WIN - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(LOSS_TIMEOUT - 1);

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t             state, state_n;
  logic [9:0]         raw_q, sym, sym_n;
  logic [18:0]        window;
  logic [RUN_W-1:0]   run_cnt, run_n;
  logic [WIN_W-1:0]   win_cnt, win_n;
  logic [IDLE_W-1:0]  idle_cnt, idle_n;
  logic [3:0]         offset, offset_n;
  logic               loss_ev;
  logic               is_tok;
  logic [1:0]         tok_val;
  logic [7:0]         q_in, dec;
  logic [6:0]         xq;

  // The top bit of raw_i can never fall inside a 10-bit window starting at
  // offset <= 9, so the window is only 19 bits wide.
  assign window = {raw_i[8:0], raw_q};

  always_comb begin
    sym_n = '0;
    case (offset)
      4'd0: sym_n = window[9:0];
      4'd1: sym_n = window[10:1];
      4'd2: sym_n = window[11:2];
      4'd3: sym_n = window[12:3];
      4'd4: sym_n = window[13:4];
      4'd5: sym_n = window[14:5];
      4'd6: sym_n = window[15:6];
      4'd7: sym_n = window[16:7];
      4'd8: sym_n = window[17:8];
      4'd9: sym_n = window[18:9];
      default: sym_n = '0;
    endcase
  end

  always_comb begin
    is_tok  = 1'b1;
    tok_val = 2'b00;
    case (sym)
      10'h354: tok_val = 2'b00;
      10'h0AB: tok_val = 2'b01;
      10'h154: tok_val = 2'b10;
      10'h2AB: tok_val = 2'b11;
      default: is_tok = 1'b0;
    endcase
  end

  // Undo the TX inversion, then the XOR/XNOR chain.
  always_comb begin
    q_in = sym[9] ? ~sym[7:0] : sym[7:0];
    xq   = q_in[7:1] ^ q_in[6:0];
    dec  = {(sym[8] ? xq : ~xq), q_in[0]};
  end

  always_comb begin
    state_n  = state;
    run_n    = run_cnt;
    win_n    = win_cnt;
    idle_n   = idle_cnt;
    offset_n = offset;
    loss_ev  = 1'b0;
    if (state == ST_SEARCH) begin
      if (is_tok && run_cnt == RUN_LAST) begin
        state_n = ST_LOCKED;
        run_n   = '0;
        win_n   = '0;
        idle_n  = '0;
      end else begin
        run_n = is_tok ? run_cnt + 1'b1 : '0;
        if (win_cnt == WIN_LAST) begin
          offset_n = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
          win_n    = '0;
          run_n    = '0;
        end else begin
          win_n = win_cnt + 1'b1;
        end
      end
    end else begin
      if (is_tok) begin
        idle_n = '0;
      end else if (idle_cnt == IDLE_LAST) begin
        state_n = ST_SEARCH;
        idle_n  = '0;
        run_n   = '0;
        win_n   = '0;
        loss_ev = 1'b1;
      end else begin
        idle_n = idle_cnt + 1'b1;
      end
    end
  end

  // de_o/data_o use the post-update lock state so that de_o never reads 1
  // in the same cycle that locked_o drops on a timeout.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      raw_q    <= '0;
      sym      <= '0;
      state    <= ST_SEARCH;
      run_cnt  <= '0;
      win_cnt  <= '0;
      idle_cnt <= '0;
      offset   <= '0;
      data_o   <= '0;
      de_o     <= 1'b0;
      ctrl_o   <= '0;
    end else begin
      raw_q    <= raw_i;
      sym      <= sym_n;
      state    <= state_n;
      run_cnt  <= run_n;
      win_cnt  <= win_n;
      idle_cnt <= idle_n;
      offset   <= offset_n;
      if (is_tok) begin
        data_o <= '0;
        de_o   <= 1'b0;
        ctrl_o <= tok_val;
      end else begin
        de_o   <= (state_n == ST_LOCKED);
        data_o <= (state_n == ST_LOCKED) ? dec : '0;
      end
    end
  end

  assign locked_o = (state == ST_LOCKED);
  assign offset_o = offset;

`ifdef TMDS_DEC_LOSS_CNT_EN
  logic [15:0] loss_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      loss_cnt <= '0;
    end else if (loss_cnt_clr_i) begin
      loss_cnt <= '0;
    end else if (loss_ev && loss_cnt != '1) begin
      loss_cnt <= loss_cnt + 16'd1;
    end
  end

  assign loss_cnt_o = loss_cnt;
`else
  logic unused_loss;
  assign unused_loss = loss_cnt_clr_i ^ loss_ev;
  assign loss_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb_tmds_channel_decoder
//   Scoreboard bench for tmds_channel_decoder. A serial-stream generator
//   produces raw words at a chosen bit skew; a reference model consumes the
//   same raw words and queues the expected output vector for each cycle.
module tb_tmds_channel_decoder;

  localparam int CTRL_RUN     = 8;
  localparam int SEARCH_WIN   = 16;
  localparam int LOSS_TIMEOUT = 32;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [9:0]  raw_i;
  logic [7:0]  data_o;
  logic        de_o;
  logic [1:0]  ctrl_o;
  logic        locked_o;
  logic [3:0]  offset_o;
  logic [15:0] loss_cnt_o;
  logic        loss_cnt_clr_i;

  always #5 clk = ~clk;

  tmds_channel_decoder #(
    .CTRL_RUN    (CTRL_RUN),
    .SEARCH_WIN  (SEARCH_WIN),
    .LOSS_TIMEOUT(LOSS_TIMEOUT)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .raw_i         (raw_i),
    .data_o        (data_o),
    .de_o          (de_o),
    .ctrl_o        (ctrl_o),
    .locked_o      (locked_o),
    .offset_o      (offset_o),
    .loss_cnt_o    (loss_cnt_o),
    .loss_cnt_clr_i(loss_cnt_clr_i)
  );

  int total = 0;
  int bad   = 0;
  int loss_en;

  logic [31:0] sb_q[$];

  // reference model state
  logic [9:0] m_prev, m_sym;
  int         m_off, m_run, m_win, m_idle, m_loss;
  logic       m_locked, m_de;
  logic [1:0] m_ctrl;
  logic [7:0] m_data;

  // stream generator state
  logic [9:0] g_prev;
  int         skew;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] observed();
    return {loss_cnt_o, offset_o, locked_o, ctrl_o, de_o, data_o};
  endfunction

  function automatic logic [31:0] ev(int loss, int off, int lk, int ctrl, int de, int data);
    return {16'(loss), 4'(off), 1'(lk), 2'(ctrl), 1'(de), 8'(data)};
  endfunction

  function automatic logic [7:0] tmds_dec(logic [9:0] s);
    logic [7:0] q, d;
    q    = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++)
      d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  // {valid, ctrl}
  function automatic logic [2:0] tok(logic [9:0] s);
    case (s)
      10'h354: return 3'b100;
      10'h0AB: return 3'b101;
      10'h154: return 3'b110;
      10'h2AB: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  task automatic model_reset();
    m_prev = '0; m_sym = '0;
    m_off = 0; m_run = 0; m_win = 0; m_idle = 0; m_loss = 0;
    m_locked = 1'b0; m_de = 1'b0; m_ctrl = '0; m_data = '0;
  endtask

  task automatic model_step(input logic [9:0] raw, input logic clr);
    logic [19:0] w;
    logic [9:0]  nsym;
    logic [2:0]  t;
    bit          lossev;
    w      = {raw, m_prev};
    w      = w >> m_off;
    nsym   = w[9:0];
    t      = tok(m_sym);
    lossev = 0;
    if (!m_locked) begin
      if (t[2] && m_run == CTRL_RUN - 1) begin
        m_locked = 1'b1; m_run = 0; m_win = 0; m_idle = 0;
      end else begin
        m_run = t[2] ? m_run + 1 : 0;
        if (m_win == SEARCH_WIN - 1) begin
          m_off = (m_off == 9) ? 0 : m_off + 1;
          m_win = 0;
          m_run = 0;
        end else begin
          m_win++;
        end
      end
    end else begin
      if (t[2]) m_idle = 0;
      else if (m_idle == LOSS_TIMEOUT - 1) begin
        m_locked = 1'b0; m_idle = 0; m_run = 0; m_win = 0; lossev = 1;
      end else m_idle++;
    end
    if (t[2]) begin
      m_de = 1'b0; m_data = '0; m_ctrl = t[1:0];
    end else begin
      m_de   = m_locked;
      m_data = m_locked ? tmds_dec(m_sym) : 8'h00;
    end
    if (loss_en != 0) begin
      if (clr) m_loss = 0;
      else if (lossev && m_loss < 65535) m_loss++;
    end
    sb_q.push_back({m_loss[15:0], m_off[3:0], m_locked, m_ctrl, m_de, m_data});
    m_sym  = nsym;
    m_prev = raw;
  endtask

  task automatic drive(input logic [9:0] raw, input logic rst, input logic clr);
    logic [31:0] exp;
    @(negedge clk);
    if (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      chk("sb", observed(), exp);
    end
    raw_i          = raw;
    rst_ni         = rst;
    loss_cnt_clr_i = clr;
    if (!rst) begin
      model_reset();
      sb_q.push_back('0);
    end else begin
      model_step(raw, clr);
    end
  endtask

  task automatic send(input logic [9:0] s, input logic clr);
    logic [19:0] tmp;
    tmp    = {s, g_prev} >> (10 - skew);
    g_prev = s;
    drive(tmp[9:0], 1'b1, clr);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive(10'h000, 1'b0, 1'b0);
    g_prev = '0;
  endtask

  task automatic peek(input string tag, input logic [31:0] exp);
    @(posedge clk);
    #1;
    chk(tag, observed(), exp);
  endtask

  initial begin
    int guard;
`ifdef TMDS_DEC_LOSS_CNT_EN
    loss_en = 1;
`else
    loss_en = 0;
`endif
    rst_ni = 1'b0; raw_i = '0; loss_cnt_clr_i = 1'b0;
    g_prev = '0; skew = 0;
    model_reset();

    do_reset(2);
    peek("reset", ev(0, 0, 0, 0, 0, 0));

    // aligned 0x354 run: lock on the 8th token's output cycle
    repeat (9) send(10'h354, 1'b0);
    peek("pre_lock", ev(0, 0, 0, 0, 0, 0));
    send(10'h354, 1'b0);
    peek("lock_8th", ev(0, 0, 1, 0, 0, 0));
    repeat (2) send(10'h354, 1'b0);

    // data decode and 3-cycle latency
    send(10'h100, 1'b0); send(10'h3FF, 1'b0); send(10'h0FF, 1'b0);
    peek("data_100", ev(0, 0, 1, 0, 1, 8'h00));
    send(10'h354, 1'b0);
    peek("data_3ff", ev(0, 0, 1, 0, 1, 8'h00));
    send(10'h354, 1'b0);
    peek("data_0ff", ev(0, 0, 1, 0, 1, 8'hFF));

    // lock loss after LOSS_TIMEOUT data symbols
    repeat (33) send(10'h0FF, 1'b0);
    peek("pre_loss", ev(0, 0, 1, 0, 1, 8'hFF));
    send(10'h0FF, 1'b0);
    peek("loss", ev(loss_en, 0, 0, 0, 0, 0));

    // relock, then a loss coinciding with a clear
    repeat (12) send(10'h354, 1'b0);
    repeat (32) send(10'h0FF, 1'b0);
    send(10'h0FF, 1'b0);
    send(10'h0FF, 1'b1);
    peek("loss_clr", ev(0, 0, 0, 0, 0, 0));

    // skewed 0x2AB stream: slip 0->1->2->3 and lock
    do_reset(1);
    peek("reset2", ev(0, 0, 0, 0, 0, 0));
    skew = 3;
    repeat (80) send(10'h2AB, 1'b0);
    peek("lock_skew3", ev(0, 3, 1, 3, 0, 0));

    // timeout, walk to offset 9, then re-skew and wrap 9->0->1->2
    skew = 9;
    repeat (200) send(10'h354, 1'b0);
    peek("lock_off9", ev(loss_en, 9, 1, 0, 0, 0));
    skew = 2;
    repeat (150) send(10'h354, 1'b0);
    peek("lock_off2", ev(2 * loss_en, 2, 1, 0, 0, 0));

    // reset in the middle of a search at offset 5
    do_reset(1);
    skew  = 7;
    guard = 0;
    while (m_off != 5 && guard < 300) begin
      send(10'h2AB, 1'b0);
      guard++;
    end
    repeat (2) send(10'h2AB, 1'b0);
    peek("pre_rst", ev(0, 5, 0, 0, 0, 0));
    do_reset(1);
    peek("rst_mid", ev(0, 0, 0, 0, 0, 0));
    repeat (40) send(10'h2AB, 1'b0);

    @(negedge clk);
    while (sb_q.size() > 0) chk("sb_tail", observed(), sb_q.pop_front());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
